// File: rtl/unit_req_arbiter_if.sv
// Request/response and decoder-side signal bundle for the 4-way request arbiter.
// The arbiter uses the slave view; the requesters plus decoder (or a bench) use master.
interface unit_req_arbiter_if;
    logic [3:0]  req_valid;
    logic [3:0]  req_wr_rd_op;
    logic [31:0] req_addr;
    logic [31:0] req_op_id;
    logic [31:0] req_wr_data;
    logic [3:0]  req_gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rd_data;
    logic [7:0]  rsp_op_id;
    logic        rsp_err;
    logic        enable_in;
    logic        valid_in;
    logic        wr_rd_op;
    logic [7:0]  addr_in;
    logic [7:0]  op_id_in;
    logic [7:0]  wr_data_in;
    logic        ready_out;
    logic [7:0]  rd_data_out;
    logic [7:0]  done_op_id;

    modport slave (
        input  req_valid, req_wr_rd_op, req_addr, req_op_id, req_wr_data,
        input  ready_out, rd_data_out, done_op_id,
        output req_gnt, rsp_valid, rsp_rd_data, rsp_op_id, rsp_err,
        output enable_in, valid_in, wr_rd_op, addr_in, op_id_in, wr_data_in
    );

    modport master (
        output req_valid, req_wr_rd_op, req_addr, req_op_id, req_wr_data,
        output ready_out, rd_data_out, done_op_id,
        input  req_gnt, rsp_valid, rsp_rd_data, rsp_op_id, rsp_err,
        input  enable_in, valid_in, wr_rd_op, addr_in, op_id_in, wr_data_in
    );
endinterface

// File: rtl/unit_req_arbiter.sv
// Round-robin arbiter that forwards one request at a time to a decoder, waits for the
// matching completion (or a timeout) and returns a one-cycle response to the owner.
module unit_req_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              rst_n,
    unit_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  count_q, count_d;
    logic        op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  op_id_q, op_id_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [3:0]  req_gnt_q, req_gnt_d;
    logic [3:0]  rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rd_data_q, rsp_rd_data_d;
    logic [7:0]  rsp_op_id_q, rsp_op_id_d;
    logic        rsp_err_q, rsp_err_d;
    logic        enable_in_q, enable_in_d;
    logic        valid_in_q, valid_in_d;
    logic        wr_rd_op_q, wr_rd_op_d;
    logic [7:0]  addr_in_q, addr_in_d;
    logic [7:0]  op_id_in_q, op_id_in_d;
    logic [7:0]  wr_data_in_q, wr_data_in_d;

    logic [7:0]  req_addr_a    [4];
    logic [7:0]  req_op_id_a   [4];
    logic [7:0]  req_wr_data_a [4];

    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [7:0]  count_sat;
    logic        timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign req_addr_a[gi]    = bus.req_addr[8*gi +: 8];
            assign req_op_id_a[gi]   = bus.req_op_id[8*gi +: 8];
            assign req_wr_data_a[gi] = bus.req_wr_data[8*gi +: 8];
        end
    endgenerate

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_found && bus.req_valid[last_q + 2'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = last_q + 2'(k);
            end
        end
    end

    // The cycle being evaluated is included, so the op lives at most TIMEOUT cycles.
    assign count_sat   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    assign timeout_hit = ({1'b0, count_q} + 9'd1) >= 9'(TIMEOUT);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        count_d       = count_q;
        op_d          = op_q;
        addr_d        = addr_q;
        op_id_d       = op_id_q;
        wr_data_d     = wr_data_q;
        req_gnt_d     = 4'b0000;
        rsp_valid_d   = 4'b0000;
        rsp_rd_data_d = 8'h00;
        rsp_op_id_d   = 8'h00;
        rsp_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    owner_d   = pick_idx;
                    last_d    = pick_idx;
                    count_d   = 8'd0;
                    op_d      = bus.req_wr_rd_op[pick_idx];
                    addr_d    = req_addr_a[pick_idx];
                    op_id_d   = req_op_id_a[pick_idx];
                    wr_data_d = req_wr_data_a[pick_idx];
                    req_gnt_d = 4'b0001 << pick_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                count_d = count_sat;
                if (bus.ready_out) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 4'b0001 << owner_q;
                    rsp_op_id_d = op_id_q;
                    rsp_err_d   = 1'b1;
                end
            end
            S_WAIT: begin
                count_d = count_sat;
                if (bus.ready_out && (bus.done_op_id == op_id_q)) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 4'b0001 << owner_q;
                    rsp_op_id_d   = op_id_q;
                    rsp_rd_data_d = op_q ? 8'h00 : bus.rd_data_out;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 4'b0001 << owner_q;
                    rsp_op_id_d = op_id_q;
                    rsp_err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enable_in_d  = (state_d == S_ISSUE) || (state_d == S_WAIT);
        valid_in_d   = (state_d == S_ISSUE);
        wr_rd_op_d   = enable_in_d ? op_d      : 1'b0;
        addr_in_d    = enable_in_d ? addr_d    : 8'h00;
        op_id_in_d   = enable_in_d ? op_id_d   : 8'h00;
        wr_data_in_d = enable_in_d ? wr_data_d : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= 2'd0;
            last_q        <= 2'd3;
            count_q       <= 8'd0;
            op_q          <= 1'b0;
            addr_q        <= 8'h00;
            op_id_q       <= 8'h00;
            wr_data_q     <= 8'h00;
            req_gnt_q     <= 4'b0000;
            rsp_valid_q   <= 4'b0000;
            rsp_rd_data_q <= 8'h00;
            rsp_op_id_q   <= 8'h00;
            rsp_err_q     <= 1'b0;
            enable_in_q   <= 1'b0;
            valid_in_q    <= 1'b0;
            wr_rd_op_q    <= 1'b0;
            addr_in_q     <= 8'h00;
            op_id_in_q    <= 8'h00;
            wr_data_in_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            count_q       <= count_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            op_id_q       <= op_id_d;
            wr_data_q     <= wr_data_d;
            req_gnt_q     <= req_gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_op_id_q   <= rsp_op_id_d;
            rsp_err_q     <= rsp_err_d;
            enable_in_q   <= enable_in_d;
            valid_in_q    <= valid_in_d;
            wr_rd_op_q    <= wr_rd_op_d;
            addr_in_q     <= addr_in_d;
            op_id_in_q    <= op_id_in_d;
            wr_data_in_q  <= wr_data_in_d;
        end
    end

    assign bus.req_gnt     = req_gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.rsp_op_id   = rsp_op_id_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.enable_in   = enable_in_q;
    assign bus.valid_in    = valid_in_q;
    assign bus.wr_rd_op    = wr_rd_op_q;
    assign bus.addr_in     = addr_in_q;
    assign bus.op_id_in    = op_id_in_q;
    assign bus.wr_data_in  = wr_data_in_q;

endmodule

// File: tb/tb_unit_req_arbiter.sv
// Bench for unit_req_arbiter: directed vector table, multi-cycle sequences and random ops
// checked against a cycle-count model of grant order, latency, timeout and response data.
module tb_unit_req_arbiter;

    localparam int T = 16;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    unit_req_arbiter_if bus ();

    unit_req_arbiter #(.TIMEOUT(T)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] rv;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] op_id;
        logic [7:0] wdata;
        logic [7:0] rd_val;
        int         d;
        int         w;
        bit         bad;
        int         exp_owner;
        int         exp_lat;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_vin;
    } vec_t;

    typedef struct {
        logic [3:0] gnt_v;
        int         lat;
        int         vin;
        logic [3:0] rsp_v;
        logic [7:0] rsp_data;
        logic [7:0] rsp_id;
        logic       rsp_e;
        int         n_gnt;
        int         n_rsp;
        int         zero_viol;
    } obs_t;

    int n_pass = 0;
    int n_chk  = 0;
    int model_last = 3;

    logic       slot_wr    [4];
    logic [7:0] slot_addr  [4];
    logic [7:0] slot_op_id [4];
    logic [7:0] slot_wdata [4];

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] all_outputs();
        return {12'h000, bus.req_gnt, bus.rsp_valid, bus.rsp_rd_data, bus.rsp_op_id, bus.rsp_err,
                bus.enable_in, bus.valid_in, bus.wr_rd_op, bus.addr_in, bus.op_id_in, bus.wr_data_in};
    endfunction

    // Randomise all four requester slots, keeping op ids distinct.
    task automatic randomize_slots();
        for (int i = 0; i < 4; i++) begin
            slot_wr[i]    = 1'($urandom);
            slot_addr[i]  = 8'($urandom);
            slot_op_id[i] = 8'((i << 6) | $urandom_range(0, 63));
            slot_wdata[i] = 8'($urandom);
        end
    endtask

    task automatic drive_slots();
        for (int i = 0; i < 4; i++) begin
            bus.req_wr_rd_op[i]      = slot_wr[i];
            bus.req_addr[8*i +: 8]   = slot_addr[i];
            bus.req_op_id[8*i +: 8]  = slot_op_id[i];
            bus.req_wr_data[8*i +: 8] = slot_wdata[i];
        end
    endtask

    function automatic int model_pick(input int last, input logic [3:0] rv);
        for (int k = 1; k <= 4; k++) begin
            if (rv[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Transfer after d stalled ISSUE cycles, completion after w unmatched WAIT cycles.
    // The op may spend TIMEOUT cycles in ISSUE+WAIT; a transfer on the last allowed
    // cycle still wins and earns one WAIT cycle in which a completion also wins.
    task automatic model_op(input int d, input int w, output int lat, output logic err, output int vin);
        int cx, cd, lim;
        cx = d + 1;
        if (cx > T) begin
            lat = T; err = 1'b1; vin = T;
        end else begin
            lim = (cx + 1 > T) ? cx + 1 : T;
            cd  = cx + w + 1;
            vin = cx;
            if (cd <= lim) begin lat = cd; err = 1'b0; end
            else begin lat = lim; err = 1'b1; end
        end
    endtask

    // Requester/decoder driver for one op; requests are withdrawn once a grant is seen.
    task automatic run_op(input logic [3:0] rv, input int d, input int w, input bit bad,
                          input logic [7:0] rd_val, output obs_t o);
        int cyc, gcyc, icnt, wcnt, after;
        bit got_rsp;
        logic [7:0] seen_id;
        o.gnt_v = 0; o.lat = 0; o.vin = 0; o.rsp_v = 0; o.rsp_data = 0; o.rsp_id = 0;
        o.rsp_e = 0; o.n_gnt = 0; o.n_rsp = 0; o.zero_viol = 0;
        cyc = 0; gcyc = 0; icnt = 0; wcnt = 0; after = 0; got_rsp = 0; seen_id = 0;
        bus.req_valid = rv;
        while (cyc < 400 && after < 3) begin
            @(negedge clock);
            cyc++;
            if (bus.req_gnt != 0) begin
                o.n_gnt++;
                if (o.n_gnt == 1) begin o.gnt_v = bus.req_gnt; gcyc = cyc; end
                bus.req_valid = 4'b0000;
            end
            if (bus.rsp_valid == 0 && (bus.rsp_rd_data != 0 || bus.rsp_op_id != 0 || bus.rsp_err))
                o.zero_viol++;
            if (bus.rsp_valid != 0) begin
                o.n_rsp++;
                if (!got_rsp) begin
                    got_rsp = 1; o.lat = cyc - gcyc; o.rsp_v = bus.rsp_valid;
                    o.rsp_data = bus.rsp_rd_data; o.rsp_id = bus.rsp_op_id; o.rsp_e = bus.rsp_err;
                end
            end
            if (got_rsp) after++;
            if (bus.valid_in) o.vin++;
            bus.ready_out   = 1'b0;
            bus.done_op_id  = 8'($urandom);
            bus.rd_data_out = 8'($urandom);
            if (bus.valid_in) begin
                icnt++;
                seen_id = bus.op_id_in;
                if (icnt == d + 1) bus.ready_out = 1'b1;
            end else if (bus.enable_in) begin
                wcnt++;
                if (wcnt == w + 1) begin
                    bus.ready_out = 1'b1; bus.done_op_id = seen_id; bus.rd_data_out = rd_val;
                end else if (bad && wcnt == w) begin
                    bus.ready_out = 1'b1; bus.done_op_id = seen_id ^ 8'h0F;
                end
            end
        end
        bus.ready_out = 1'b0;
    endtask

    task automatic check_op(input string tag, input obs_t o, input int owner, input int lat,
                            input logic err, input logic [7:0] rd, input logic [7:0] id, input int vin);
        chk({tag, ".gnt"}, 64'(o.gnt_v), 64'(4'b0001 << owner));
        chk({tag, ".n_gnt"}, 64'(o.n_gnt), 64'd1);
        chk({tag, ".n_rsp"}, 64'(o.n_rsp), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(o.rsp_v), 64'(4'b0001 << owner));
        chk({tag, ".lat"}, 64'(o.lat), 64'(lat));
        chk({tag, ".err"}, 64'(o.rsp_e), 64'(err));
        chk({tag, ".rd_data"}, 64'(o.rsp_data), 64'(rd));
        chk({tag, ".op_id"}, 64'(o.rsp_id), 64'(id));
        chk({tag, ".valid_in_cycles"}, 64'(o.vin), 64'(vin));
        chk({tag, ".idle_rsp_zero"}, 64'(o.zero_viol), 64'd0);
        $display("op %s: gnt=%b lat=%0d err=%0b rd=%02h id=%02h vin=%0d", tag, o.gnt_v, o.lat,
                 o.rsp_e, o.rsp_data, o.rsp_id, o.vin);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int lat, vin, own;
        logic err;
        logic [3:0] rv;
        logic [7:0] rd_val;
        int d, w;
        bit bad;
        logic [3:0] g_v [5];
        logic [3:0] r_v [5];
        logic [7:0] r_id [5];
        int g_cy [5];
        int gcount, rcount, rsp_cnt;
        logic [3:0] g;

        // rv, wr, addr, op_id, wdata, rd_val, d, w, bad, owner, lat, err, rd, vin
        vecs[0] = '{4'b0100, 1'b0, 8'h12, 8'h5A, 8'h00, 8'hC3, 3, 0, 0, 2, 5, 1'b0, 8'hC3, 4};
        vecs[1] = '{4'b0001, 1'b1, 8'h40, 8'h07, 8'h99, 8'h11, 0, 1000, 0, 0, 16, 1'b1, 8'h00, 1};
        vecs[2] = '{4'b1000, 1'b1, 8'h41, 8'h07, 8'h55, 8'h22, 0, 2, 1, 3, 4, 1'b0, 8'h00, 1};
        vecs[3] = '{4'b0011, 1'b0, 8'h02, 8'h21, 8'h00, 8'h9E, 1, 0, 0, 0, 3, 1'b0, 8'h9E, 2};
        vecs[4] = '{4'b1010, 1'b0, 8'h03, 8'h33, 8'h00, 8'h44, 0, 5, 0, 1, 7, 1'b0, 8'h44, 1};
        vecs[5] = '{4'b1111, 1'b0, 8'h04, 8'h66, 8'h00, 8'h77, 1000, 0, 0, 2, 16, 1'b1, 8'h00, 16};
        vecs[6] = '{4'b0011, 1'b0, 8'h05, 8'h2B, 8'h00, 8'h5C, 15, 0, 0, 0, 17, 1'b0, 8'h5C, 16};
        vecs[7] = '{4'b0110, 1'b0, 8'h06, 8'h3C, 8'h00, 8'h6D, 15, 1, 0, 1, 17, 1'b1, 8'h00, 16};
        vecs[8] = '{4'b1001, 1'b0, 8'h07, 8'h4D, 8'h00, 8'hA5, 0, 14, 0, 3, 16, 1'b0, 8'hA5, 1};
        vecs[9] = '{4'b1000, 1'b1, 8'h08, 8'h5E, 8'h31, 8'h00, 0, 15, 0, 3, 16, 1'b1, 8'h00, 1};

        bus.req_valid = 4'b1111; bus.req_wr_rd_op = 0; bus.req_addr = 0; bus.req_op_id = 0;
        bus.req_wr_data = 0; bus.ready_out = 1'b1; bus.rd_data_out = 0; bus.done_op_id = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset.outputs_zero", all_outputs(), 64'd0);
        chk("reset.no_grant", 64'(bus.req_gnt), 64'd0);
        bus.req_valid = 4'b0000; bus.ready_out = 1'b0;
        rst_n = 1'b1;
        @(negedge clock);
        chk("reset.idle_after_release", all_outputs(), 64'd0);

        for (int i = 0; i < 10; i++) begin
            randomize_slots();
            own = vecs[i].exp_owner;
            slot_wr[own] = vecs[i].wr; slot_addr[own] = vecs[i].addr;
            slot_op_id[own] = vecs[i].op_id; slot_wdata[own] = vecs[i].wdata;
            drive_slots();
            run_op(vecs[i].rv, vecs[i].d, vecs[i].w, vecs[i].bad, vecs[i].rd_val, o);
            check_op($sformatf("vec%0d", i), o, own, vecs[i].exp_lat, vecs[i].exp_err,
                     vecs[i].exp_rd, vecs[i].op_id, vecs[i].exp_vin);
            model_last = own;
        end

        // All four requesting continuously with an immediate, echoing decoder.
        for (int i = 0; i < 4; i++) begin
            slot_wr[i] = 1'b0; slot_addr[i] = 8'(i); slot_op_id[i] = 8'(8'h10 + i); slot_wdata[i] = 0;
        end
        for (int k = 0; k < 5; k++) begin g_v[k] = 0; r_v[k] = 0; r_id[k] = 0; g_cy[k] = 0; end
        drive_slots();
        gcount = 0; rcount = 0;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 60 && rcount < 5; c++) begin
            @(negedge clock);
            if (bus.req_gnt != 0 && gcount < 5) begin
                g_v[gcount] = bus.req_gnt; g_cy[gcount] = c; gcount++;
                if (gcount == 5) bus.req_valid = 4'b0000;
            end
            if (bus.rsp_valid != 0 && rcount < 5) begin
                r_v[rcount] = bus.rsp_valid; r_id[rcount] = bus.rsp_op_id; rcount++;
            end
            bus.ready_out = bus.enable_in; bus.done_op_id = bus.op_id_in; bus.rd_data_out = 8'hEE;
        end
        bus.ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr.gnt%0d", k), 64'(g_v[k]), 64'(4'b0001 << (k % 4)));
            chk($sformatf("rr.rsp%0d", k), 64'(r_v[k]), 64'(4'b0001 << (k % 4)));
            chk($sformatf("rr.rsp_id%0d", k), 64'(r_id[k]), 64'(8'h10 + (k % 4)));
            if (k > 0) chk($sformatf("rr.gap%0d", k), 64'(g_cy[k] - g_cy[k-1]), 64'd4);
            $display("rr grant %0d: gnt=%b rsp=%b id=%02h", k, g_v[k], r_v[k], r_id[k]);
        end
        model_last = 0;
        @(negedge clock);

        // Reset while the op is waiting on a decoder that never answers.
        randomize_slots();
        drive_slots();
        g = 0; rsp_cnt = 0;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.req_gnt != 0) begin g = bus.req_gnt; bus.req_valid = 4'b0000; end
            if (bus.rsp_valid != 0) rsp_cnt++;
            bus.ready_out = bus.valid_in; bus.done_op_id = ~bus.op_id_in;
        end
        chk("rst_mid.gnt", 64'(g), 64'b0100);
        chk("rst_mid.in_wait", 64'({bus.enable_in, bus.valid_in}), 64'b10);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111; bus.ready_out = 1'b1; bus.done_op_id = slot_op_id[2];
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk($sformatf("rst_mid.outputs_zero%0d", c), all_outputs(), 64'd0);
            if (bus.rsp_valid != 0) rsp_cnt++;
        end
        chk("rst_mid.no_rsp", 64'(rsp_cnt), 64'd0);
        bus.ready_out = 1'b0;
        rst_n = 1'b1;
        @(negedge clock);
        chk("rst_mid.priority0", 64'(bus.req_gnt), 64'b0001);
        bus.req_valid = 4'b0000;
        rsp_cnt = 0; r_v[0] = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid != 0) begin rsp_cnt++; r_v[0] = bus.rsp_valid; end
            bus.ready_out = bus.enable_in; bus.done_op_id = bus.op_id_in;
            @(negedge clock);
        end
        bus.ready_out = 1'b0;
        chk("rst_mid.post_rsp_count", 64'(rsp_cnt), 64'd1);
        chk("rst_mid.post_rsp_owner", 64'(r_v[0]), 64'b0001);
        $display("reset mid-op: first grant after release to requester 0, rsp=%b", r_v[0]);
        model_last = 0;

        for (int n = 0; n < 40; n++) begin
            randomize_slots();
            drive_slots();
            rv = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 4))
                0: d = 0;
                1: d = $urandom_range(0, 3);
                2: d = $urandom_range(13, 17);
                3: d = 1000;
                default: d = $urandom_range(0, 6);
            endcase
            case ($urandom_range(0, 3))
                0: w = $urandom_range(0, 3);
                1: w = $urandom_range(12, 16);
                2: w = 1000;
                default: w = $urandom_range(0, 8);
            endcase
            bad = (w >= 1) ? 1'($urandom) : 1'b0;
            rd_val = 8'($urandom);
            own = model_pick(model_last, rv);
            model_op(d, w, lat, err, vin);
            run_op(rv, d, w, bad, rd_val, o);
            check_op($sformatf("rand%0d", n), o, own, lat, err,
                     (err || slot_wr[own]) ? 8'h00 : rd_val, slot_op_id[own], vin);
            model_last = own;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
